// File: rtl/mmp_pkg.sv
// Shared constants and small types for the mmp sample-path blocks.
package mmp_pkg;

    localparam logic HIGH       = 1'b1;
    localparam logic LOW        = 1'b0;
    localparam int   DATA_W_DEF = 16;

    // Encoded as {write_done, read_done} so it can be built straight from the two enables.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mmp_sample_fifo_if.sv
// Producer/consumer bus of the sample FIFO; the slave modport is the FIFO side.
interface mmp_sample_fifo_if
    import mmp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH     = 2,
    parameter int DEPTH  = 8
) ();

    // Strobe protocol, no back-pressure: each one-cycle i_WR_STB / i_RD_STB is an
    // unconditional request. Writes while full are dropped (o_OVF), reads while empty
    // return no frame (o_UNF); o_RD_VALID pulses one cycle after an accepted read.
    logic                            i_WR_STB;
    logic [CH*DATA_W-1:0]            i_WR_DATA;
    logic                            i_RD_STB;
    logic                            i_CLR_FLAGS;
    logic [CH*DATA_W-1:0]            o_RD_DATA;
    logic                            o_RD_VALID;
    logic                            o_FULL;
    logic                            o_EMPTY;
    logic [level_width(DEPTH)-1:0]   o_LEVEL;
    logic                            o_OVF;
    logic                            o_UNF;

    modport master (
        output i_WR_STB, i_WR_DATA, i_RD_STB, i_CLR_FLAGS,
        input  o_RD_DATA, o_RD_VALID, o_FULL, o_EMPTY, o_LEVEL, o_OVF, o_UNF
    );

    modport slave (
        input  i_WR_STB, i_WR_DATA, i_RD_STB, i_CLR_FLAGS,
        output o_RD_DATA, o_RD_VALID, o_FULL, o_EMPTY, o_LEVEL, o_OVF, o_UNF
    );

endinterface

// File: rtl/mmp_sample_ram.sv
// Frame storage: register array with one write port and one registered read port.
module mmp_sample_ram #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_n,
    input  logic                     i_WE,
    input  logic [$clog2(DEPTH)-1:0] i_WADDR,
    input  logic [W-1:0]             i_WDATA,
    input  logic                     i_RE,
    input  logic [$clog2(DEPTH)-1:0] i_RADDR,
    input  logic                     i_RCLR,
    output logic [W-1:0]             o_RDATA
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    // Contents are never reset; only the read register has a defined reset value.
    always_ff @(posedge i_CLK) begin
        if (i_WE) begin
            r_mem[i_WADDR] <= i_WDATA;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_rdata <= '0;
        end else if (i_RE) begin
            r_rdata <= r_mem[i_RADDR];
        end else if (i_RCLR) begin
            r_rdata <= '0;
        end
    end

    assign o_RDATA = r_rdata;

endmodule

// File: rtl/mmp_sample_fifo.sv
// Multi-channel signed sample FIFO with sticky overflow/underflow flags.
// Build option MMP_FIFO_HOLD_LAST_EN: on underflow hold the last frame instead of silence.
module mmp_sample_fifo
    import mmp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH     = 2,
    parameter int DEPTH  = 8
) (
    input logic              i_CLK,
    input logic              i_RST_n,
    mmp_sample_fifo_if.slave io_fifo
);

    localparam int FW = CH * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic          r_armed;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_rd_valid;
    logic          r_ovf;
    logic          r_unf;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_req;
    logic          w_rd_req;
    logic          w_rd_do;
    logic          w_wr_do;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          w_rd_clr;
    fifo_op_e      w_op;
    logic [FW-1:0] w_rd_data;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);

    // Strobes are ignored on the first edge after reset release.
    assign w_wr_req = r_armed & io_fifo.i_WR_STB;
    assign w_rd_req = r_armed & io_fifo.i_RD_STB;

    // A read while full frees the slot the write lands in; a read while empty never
    // sees the frame written in the same cycle.
    assign w_rd_do   = w_rd_req & ~w_empty;
    assign w_wr_do   = w_wr_req & (~w_full | w_rd_do);
    assign w_ovf_set = w_wr_req & w_full & ~w_rd_do;
    assign w_unf_set = w_rd_req & w_empty;
    assign w_op      = fifo_op_e'({w_wr_do, w_rd_do});

`ifdef MMP_FIFO_HOLD_LAST_EN
    assign w_rd_clr = LOW;
`else
    assign w_rd_clr = w_unf_set;
`endif

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_armed    <= LOW;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= LOW;
            r_ovf      <= LOW;
            r_unf      <= LOW;
        end else begin
            r_armed    <= HIGH;
            r_rd_valid <= w_rd_do;
            if (w_wr_do) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_do) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case (w_op)
                OP_WR:   r_level <= r_level + LW'(1);
                OP_RD:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            // Setting wins over a same-cycle clear.
            if (w_ovf_set) begin
                r_ovf <= HIGH;
            end else if (io_fifo.i_CLR_FLAGS) begin
                r_ovf <= LOW;
            end
            if (w_unf_set) begin
                r_unf <= HIGH;
            end else if (io_fifo.i_CLR_FLAGS) begin
                r_unf <= LOW;
            end
        end
    end

    mmp_sample_ram #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_CLK   (i_CLK),
        .i_RST_n (i_RST_n),
        .i_WE    (w_wr_do),
        .i_WADDR (r_wr_ptr),
        .i_WDATA (io_fifo.i_WR_DATA),
        .i_RE    (w_rd_do),
        .i_RADDR (r_rd_ptr),
        .i_RCLR  (w_rd_clr),
        .o_RDATA (w_rd_data)
    );

    assign io_fifo.o_RD_DATA  = w_rd_data;
    assign io_fifo.o_RD_VALID = r_rd_valid;
    assign io_fifo.o_FULL     = w_full;
    assign io_fifo.o_EMPTY    = w_empty;
    assign io_fifo.o_LEVEL    = r_level;
    assign io_fifo.o_OVF      = r_ovf;
    assign io_fifo.o_UNF      = r_unf;

endmodule

// File: tb/tb_mmp_sample_fifo.sv
// Bench for mmp_sample_fifo: DEPTH=8 and DEPTH=4 instances driven in lockstep.
module tb_mmp_sample_fifo;

    typedef logic [31:0] frame_t;

    typedef struct {
        logic   wr;
        logic   rd;
        logic   clr;
        frame_t d;
        logic   e_valid;
        frame_t e_data;
        int     e_level;
        logic   e_empty;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: one frame queue and flag set per instance (0 -> DEPTH 8, 1 -> DEPTH 4).
    frame_t mq [2][$];
    frame_t m_data  [2];
    logic   m_valid [2];
    logic   m_ovf   [2];
    logic   m_unf   [2];
    logic   m_first [2];

    always #5 clk = ~clk;

    mmp_sample_fifo_if #(.DATA_W(16), .CH(2), .DEPTH(8)) b8 ();
    mmp_sample_fifo_if #(.DATA_W(16), .CH(2), .DEPTH(4)) b4 ();

    mmp_sample_fifo #(.DATA_W(16), .CH(2), .DEPTH(8)) u_dut8 (
        .i_CLK   (clk),
        .i_RST_n (rst_n),
        .io_fifo (b8.slave)
    );

    mmp_sample_fifo #(.DATA_W(16), .CH(2), .DEPTH(4)) u_dut4 (
        .i_CLK   (clk),
        .i_RST_n (rst_n),
        .io_fifo (b4.slave)
    );

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    function automatic frame_t fr(input int i);
        logic [15:0] a;
        a = 16'(i);
        return {16'(-a), a};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            m_ovf[k]   = 1'b0;
            m_unf[k]   = 1'b0;
            m_first[k] = 1'b1;
        end
    endtask

    task automatic model_edge(input int k, input logic wr, input logic rd, input logic clr,
                              input frame_t d);
        int pre;
        bit rd_ok;
        if (m_first[k]) begin
            m_first[k] = 1'b0;
            m_valid[k] = 1'b0;
        end else begin
            pre   = mq[k].size();
            rd_ok = rd && (pre > 0);
            if (clr) begin
                m_ovf[k] = 1'b0;
                m_unf[k] = 1'b0;
            end
            m_valid[k] = rd_ok;
            if (rd_ok) begin
                m_data[k] = mq[k].pop_front();
            end else if (rd) begin
                m_unf[k] = 1'b1;
`ifndef MMP_FIFO_HOLD_LAST_EN
                m_data[k] = '0;
`endif
            end
            if (wr) begin
                if (pre < dep(k) || rd_ok) mq[k].push_back(d);
                else m_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            frame_t a_d;
            logic   a_v, a_f, a_e, a_o, a_u;
            int     a_l;
            string  p;
            if (k == 0) begin
                a_d = b8.o_RD_DATA; a_v = b8.o_RD_VALID; a_f = b8.o_FULL; a_e = b8.o_EMPTY;
                a_o = b8.o_OVF; a_u = b8.o_UNF; a_l = int'(b8.o_LEVEL);
            end else begin
                a_d = b4.o_RD_DATA; a_v = b4.o_RD_VALID; a_f = b4.o_FULL; a_e = b4.o_EMPTY;
                a_o = b4.o_OVF; a_u = b4.o_UNF; a_l = int'(b4.o_LEVEL);
            end
            p = $sformatf("d%0d", dep(k));
            check({p, "_data"},  a_d, m_data[k]);
            check({p, "_valid"}, a_v, m_valid[k]);
            check({p, "_level"}, a_l, mq[k].size());
            check({p, "_full"},  a_f, mq[k].size() == dep(k));
            check({p, "_empty"}, a_e, mq[k].size() == 0);
            check({p, "_ovf"},   a_o, m_ovf[k]);
            check({p, "_unf"},   a_u, m_unf[k]);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic clr, input frame_t d);
        b8.i_WR_STB = wr; b8.i_RD_STB = rd; b8.i_CLR_FLAGS = clr; b8.i_WR_DATA = d;
        b4.i_WR_STB = wr; b4.i_RD_STB = rd; b4.i_CLR_FLAGS = clr; b4.i_WR_DATA = d;
    endtask

    // One clock of stimulus; rel releases reset at the start of this cycle.
    task automatic step(input logic wr, input logic rd, input logic clr, input frame_t d,
                        input logic rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        drive(wr, rd, clr, d);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) model_edge(k, wr, rd, clr, d);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_level8"}, b8.o_LEVEL, 0);
        check({tag, "_empty8"}, b8.o_EMPTY, 1);
        check({tag, "_full8"},  b8.o_FULL, 0);
        check({tag, "_valid8"}, b8.o_RD_VALID, 0);
        check({tag, "_ovf8"},   b8.o_OVF, 0);
        check({tag, "_unf8"},   b8.o_UNF, 0);
        check({tag, "_data8"},  b8.o_RD_DATA, 0);
        check({tag, "_level4"}, b4.o_LEVEL, 0);
        check({tag, "_ovf4"},   b4.o_OVF, 0);
        check({tag, "_data4"},  b4.o_RD_DATA, 0);
    endtask

    vec_t tbl [7];

    initial begin
        frame_t exp_uf;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_0001, 1'b0, 32'h0,          1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h8000_7FFF, 1'b0, 32'h0,          2, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'hEDCC_1234, 1'b0, 32'h0,          3, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_0001, 2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_7FFF, 1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hEDCC_1234, 0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'hEDCC_1234, 0, 1'b1};

        drive(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("rst");

        // Write strobe coinciding with reset release is ignored.
        step(1'b1, 1'b0, 1'b0, fr(99), 1'b1);
        check("release_wr_ignored", b8.o_LEVEL, 0);

        // Three frames through, latency and order.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d, 1'b0);
            check($sformatf("tbl%0d_valid", i), b8.o_RD_VALID, tbl[i].e_valid);
            check($sformatf("tbl%0d_data", i),  b8.o_RD_DATA,  tbl[i].e_data);
            check($sformatf("tbl%0d_level", i), b8.o_LEVEL,    tbl[i].e_level);
            check($sformatf("tbl%0d_empty", i), b8.o_EMPTY,    tbl[i].e_empty);
        end

        // Fill past capacity.
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, 1'b0, fr(i), 1'b0);
            if (i == 8) check("fill_full_at8", b8.o_FULL, 1);
        end
        check("ovf_set", b8.o_OVF, 1);
        check("ovf_level", b8.o_LEVEL, 8);
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("ovf_clr", b8.o_OVF, 0);

        // Simultaneous read and write while full.
        step(1'b1, 1'b1, 1'b0, fr(10), 1'b0);
        check("rw_full_data", b8.o_RD_DATA, fr(1));
        check("rw_full_valid", b8.o_RD_VALID, 1);
        check("rw_full_level", b8.o_LEVEL, 8);
        check("rw_full_ovf", b8.o_OVF, 0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, '0, 1'b0);
            check("drain_data", b8.o_RD_DATA, (i < 7) ? fr(i + 2) : fr(10));
        end

        // Underflow, set-over-clear priority, then clear.
`ifdef MMP_FIFO_HOLD_LAST_EN
        exp_uf = fr(10);
`else
        exp_uf = '0;
`endif
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("unf_valid", b8.o_RD_VALID, 0);
        check("unf_flag", b8.o_UNF, 1);
        check("unf_data", b8.o_RD_DATA, exp_uf);
        step(1'b0, 1'b1, 1'b1, '0, 1'b0);
        check("unf_set_wins", b8.o_UNF, 1);
        step(1'b0, 1'b0, 1'b1, '0, 1'b0);
        check("unf_clr", b8.o_UNF, 0);

        // Write and read together on an empty FIFO: no bypass.
        step(1'b1, 1'b1, 1'b0, fr(11), 1'b0);
        check("we_rd_valid", b8.o_RD_VALID, 0);
        check("we_rd_level", b8.o_LEVEL, 1);
        check("we_rd_unf", b8.o_UNF, 1);
        step(1'b0, 1'b1, 1'b1, '0, 1'b0);
        check("we_rd_next", b8.o_RD_DATA, fr(11));

        // Pointer wrap on the DEPTH=4 instance.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, fr(100 + i), 1'b0);
            step(1'b0, 1'b1, 1'b0, '0, 1'b0);
            check("wrap_data4", b4.o_RD_DATA, fr(100 + i));
        end
        check("wrap_ovf4", b4.o_OVF, 0);
        check("wrap_unf4", b4.o_UNF, 0);

        // Asynchronous reset mid-operation.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 1'b0, fr(200 + i), 1'b0);
        check("pre_rst_level8", b8.o_LEVEL, 5);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(negedge clk);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("post_rst_unf", b8.o_UNF, 1);
        check("post_rst_valid", b8.o_RD_VALID, 0);

        // Randomized traffic: write-heavy then read-heavy.
        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
            r = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
            c = ($urandom_range(0, 15) == 0);
            step(w, r, c, frame_t'($urandom()), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
